mips_multi_cycle: RTL and testbench

Multi-cycle MIPS-32 core, the successor to the single-cycle core. It replaces the single-cycle datapath, divided memory clock and split instruction/data ports with one unified memory port that uses a req/ready handshake. Memories of any latency run on the core clock. The core also traps illegal and misaligned accesses into a halt state. It contains the FSM controller, the datapath, the 32x32 register file and the ALU.

---
 rtl/mips_multi_cycle.sv | 167 ++++++++++++++++
 tb/tb_mips_multi_cycle.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS-32 core: FSM controller, datapath, 32x32 register file and ALU
// sharing one req/ready memory port. Illegal or misaligned accesses trap into HALT.
module mips_multi_cycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          EXT_ISA  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state;
    logic [31:0] pc_q, pc_plus4, ir, a, b, imm_ext, alu_out, mdr;
    logic [31:0] rf [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wb_reg;
    logic        legal, is_branch, br_taken, is_sw;
    logic [31:0] alu_y, alu_res, br_target;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign wb_reg = (op == OP_R) ? rd : rt;

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R:                                  legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW:   legal = 1'b1;
            OP_BNE, OP_SLTI, OP_ANDI, OP_ORI:      legal = EXT_ISA;
            default:                               legal = 1'b0;
        endcase
    end

    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign br_taken  = (op == OP_BEQ) ? (a == b) : (a != b);
    assign br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign is_sw     = (op == OP_SW);
    assign alu_y     = (op == OP_R) ? b : imm_ext;

    always_comb begin
        alu_res = a + alu_y;
        case (op)
            OP_R: begin
                case (funct)
                    F_SUB:   alu_res = a - alu_y;
                    F_AND:   alu_res = a & alu_y;
                    F_OR:    alu_res = a | alu_y;
                    F_SLT:   alu_res = {31'b0, $signed(a) < $signed(alu_y)};
                    default: alu_res = a + alu_y;
                endcase
            end
            OP_ANDI: alu_res = a & alu_y;
            OP_ORI:  alu_res = a | alu_y;
            OP_SLTI: alu_res = {31'b0, $signed(a) < $signed(alu_y)};
            default: alu_res = a + alu_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc_q     <= RESET_PC;
            pc_plus4 <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm_ext  <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir       <= mem_rdata;
                        pc_plus4 <= pc_q + 32'd4;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    imm_ext <= (op == OP_ANDI || op == OP_ORI) ? {16'h0, ir[15:0]}
                                                               : {{16{ir[15]}}, ir[15:0]};
                    if (!legal) begin
                        state <= HALT;
                    end else if (op == OP_J) begin
                        pc_q  <= {pc_plus4[31:28], ir[25:0], 2'b00};
                        state <= FETCH;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    alu_out <= alu_res;
                    if (is_branch) begin
                        pc_q  <= br_taken ? br_target : pc_plus4;
                        state <= FETCH;
                    end else if (op == OP_LW || op == OP_SW) begin
                        state <= (alu_res[1:0] != 2'b00) ? HALT : MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (is_sw) begin
                            pc_q  <= pc_plus4;
                            state <= FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    if (wb_reg != 5'd0) rf[wb_reg] <= (op == OP_LW) ? mdr : alu_out;
                    pc_q  <= pc_plus4;
                    state <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end

    // Port strobes come from state (and rst) only, so a stalled request holds steady.
    assign mem_req   = !rst && (state == FETCH || state == MEM);
    assign mem_we    = !rst && (state == MEM) && is_sw;
    assign mem_addr  = (state == MEM) ? alu_out : pc_q;
    assign mem_wdata = (!rst && state == MEM && is_sw) ? b : 32'h0;
    assign pc        = rst ? RESET_PC : pc_q;
    assign halted    = !rst && (state == HALT);
    assign retire    = !rst && ((state == DECODE && legal && op == OP_J) ||
                                (state == EXEC && is_branch) ||
                                (state == MEM && is_sw && mem_ready) ||
                                (state == WB));
endmodule

// File: tb/tb_mips_multi_cycle.sv
// Bench for mips_multi_cycle: wait-state memory model, directed programs, a vector
// table of single-instruction cases and random ALU programs checked against an ISA model.
module tb_mips_multi_cycle;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic        req0, we0, retire0, halted0;
    logic [31:0] addr0, wdata0, pc0;
    logic [31:0] rdata0;
    logic        ready0;
    assign rdata0 = 32'h3421_0001;  // ori $1,$1,1
    assign ready0 = 1'b1;

    always #5 clk = ~clk;

    mips_multi_cycle #(.RESET_PC(32'h100), .EXT_ISA(1'b1)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .retire(retire), .halted(halted));

    mips_multi_cycle #(.RESET_PC(32'h0), .EXT_ISA(1'b0)) dut0 (
        .clk(clk), .rst(rst), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_ready(ready0),
        .pc(pc0), .retire(retire0), .halted(halted0));

    // Memory model and monitors; only this process writes mem and the counters.
    logic [31:0] mem [0:1023];
    logic [31:0] img [0:1023];
    int load_gen = 0, last_gen = 0;
    int fixed_wait = 0;
    bit rand_mode = 1'b0;
    int rw = 0, wcnt = 0, cur_w;
    int cyc = 0, ret_cnt = 0, acc_cnt = 0, wr8 = 0, wr8ok = 0;
    int ret_cyc [0:1023];
    int wlog [0:1023];

    assign cur_w     = rand_mode ? rw : fixed_wait;
    assign mem_ready = mem_req && (wcnt >= cur_w);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (load_gen != last_gen) begin
            for (int i = 0; i < 1024; i++) mem[i] = img[i];
            last_gen <= load_gen;
        end
        if (!rst) cyc <= cyc + 1;
        if (retire) begin
            ret_cyc[ret_cnt % 1024] <= cyc + 1;
            ret_cnt <= ret_cnt + 1;
        end
        if (mem_req && mem_ready) begin
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            wlog[acc_cnt % 1024] <= cur_w;
            acc_cnt <= acc_cnt + 1;
            wcnt <= 0;
            rw <= $urandom_range(0, 3);
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
        if (mem_req && mem_we && mem_addr == 32'h8) begin
            wr8 <= wr8 + 1;
            if (mem_wdata == 32'h5) wr8ok <= wr8ok + 1;
        end
    end

    int n_chk = 0, n_fail = 0;
    int c0 = 0, r0 = 0, a0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] f);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] tgt);
        return {6'h02, tgt[27:2]};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img[i] = 32'h0;
    endtask
    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        img[addr[11:2]] = w;
    endtask

    task automatic release_rst();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c0 = cyc; r0 = ret_cnt; a0 = acc_cnt;
    endtask
    task automatic boot();
        rst = 1'b1;
        load_gen++;
        @(negedge clk);
        release_rst();
    endtask

    task automatic wait_ret(input int n, input int budget);
        int k = 0;
        while ((ret_cnt - r0) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("retire_count_%0d", n), 32'(ret_cnt - r0 >= n ? n : ret_cnt - r0), 32'(n));
    endtask

    function automatic int rc(input int i);
        return ret_cyc[(r0 + i - 1) % 1024] - c0;
    endfunction

    typedef struct {
        logic [31:0] ins;
        bit          halt;
        logic [31:0] npc;
        int          cyc;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [10];
        logic [31:0] bpc [7];
        int          bcy [7];
        logic [31:0] r [8];
        logic [31:0] w, v, imm;
        int k, reqs, a1, kind, rs, rt, rd, exp_cyc;

        vt[0] = '{32'h1021_FFFF, 1'b0, 32'h20,  3};  // beq $1,$1,-1 self-loop
        vt[1] = '{32'h1422_0004, 1'b0, 32'h24,  3};  // bne $1,$2 not taken
        vt[2] = '{32'h1000_0002, 1'b0, 32'h2C,  3};  // beq $0,$0,+2 taken
        vt[3] = '{32'h0800_0040, 1'b0, 32'h100, 2};  // j 0x100
        vt[4] = '{32'h2000_0001, 1'b0, 32'h24,  4};  // addi $0,$0,1
        vt[5] = '{32'hFC00_0000, 1'b1, 32'h20,  0};  // opcode 0x3F
        vt[6] = '{32'h8C01_0006, 1'b1, 32'h20,  0};  // lw misaligned
        vt[7] = '{32'hAC00_0002, 1'b1, 32'h20,  0};  // sw misaligned
        vt[8] = '{32'h0000_003F, 1'b1, 32'h20,  0};  // bad funct
        vt[9] = '{32'h3421_0001, 1'b0, 32'h24,  4};  // ori legal with EXT_ISA=1

        // Reset and zero-wait ALU program
        clear_img();
        put(32'h100, enc_i(6'h08, 0, 1, 16'd5));
        put(32'h104, enc_i(6'h08, 0, 2, 16'hFFFD));
        put(32'h108, enc_r(1, 2, 3, 6'h20));
        put(32'h10C, enc_r(2, 1, 4, 6'h2A));
        put(32'h110, enc_r(2, 1, 5, 6'h22));
        put(32'h114, enc_i(6'h2B, 0, 3, 16'h200));
        put(32'h118, enc_i(6'h2B, 0, 4, 16'h204));
        put(32'h11C, enc_i(6'h2B, 0, 5, 16'h208));
        put(32'h120, enc_i(6'h04, 0, 0, 16'hFFFF));
        load_gen++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_req", i), 32'(mem_req), 32'h0);
            chk($sformatf("rst%0d_pc", i), pc, 32'h100);
            chk($sformatf("rst%0d_misc", i), {28'h0, mem_we, retire, halted, |mem_wdata}, 32'h0);
        end
        rst = 1'b0;
        c0 = cyc; r0 = ret_cnt; a0 = acc_cnt;
        #1;
        chk("first_req", {31'h0, mem_req}, 32'h1);
        chk("first_addr", mem_addr, 32'h100);
        chk("first_we", {31'h0, mem_we}, 32'h0);
        wait_ret(9, 200);
        for (int i = 1; i <= 8; i++) chk($sformatf("alu_retire%0d_cyc", i), 32'(rc(i)), 32'(4 * i));
        chk("alu_r3", mem[32'h200 >> 2], 32'h2);
        chk("alu_r4", mem[32'h204 >> 2], 32'h1);
        chk("alu_r5", mem[32'h208 >> 2], 32'hFFFF_FFF8);
        wait_ret(10, 50);
        chk("beq_loop_pc", pc, 32'h120);
        chk("beq_loop_cyc", 32'(rc(10) - rc(9)), 32'd3);
        chk("ext0_halted", {31'h0, halted0}, 32'h1);
        chk("ext0_pc", pc0, 32'h0);
        chk("ext0_req", {31'h0, req0}, 32'h0);

        // Three wait states on every access
        fixed_wait = 3;
        clear_img();
        put(32'h100, enc_i(6'h08, 0, 1, 16'd5));
        put(32'h104, enc_i(6'h2B, 0, 1, 16'h8));
        put(32'h108, enc_i(6'h23, 0, 6, 16'h8));
        put(32'h10C, enc_i(6'h2B, 0, 6, 16'h20C));
        put(32'h110, enc_i(6'h04, 0, 0, 16'hFFFF));
        boot();
        k = wr8; reqs = wr8ok;
        wait_ret(4, 400);
        chk("ws_addi_cyc", 32'(rc(1)), 32'd7);
        chk("ws_sw_cyc", 32'(rc(2) - rc(1)), 32'd10);
        chk("ws_lw_cyc", 32'(rc(3) - rc(2)), 32'd11);
        chk("ws_wr_cycles", 32'(wr8 - k), 32'd4);
        chk("ws_wr_stable", 32'(wr8ok - reqs), 32'd4);
        chk("ws_mem8", mem[2], 32'h5);
        chk("ws_r6", mem[32'h20C >> 2], 32'h5);

        // Branch and jump sequence
        fixed_wait = 0;
        clear_img();
        put(32'h100, enc_j(32'h20));
        put(32'h020, enc_i(6'h05, 0, 0, 16'd5));
        put(32'h024, enc_i(6'h08, 0, 0, 16'd7));
        put(32'h028, enc_i(6'h2B, 0, 0, 16'h210));
        put(32'h02C, enc_j(32'h30));
        put(32'h030, enc_j(32'h100));
        put(32'h210, 32'hDEAD_BEEF);
        bpc = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h100, 32'h20};
        bcy = '{2, 5, 9, 13, 15, 17, 19};
        boot();
        for (int i = 0; i < 7; i++) begin
            wait_ret(i + 1, 50);
            chk($sformatf("br%0d_pc", i), pc, bpc[i]);
            chk($sformatf("br%0d_cyc", i), 32'(rc(i + 1)), 32'(bcy[i]));
        end
        chk("r0_write_discard", mem[32'h210 >> 2], 32'h0);

        // Single-instruction vectors placed at 0x20 behind a jump
        for (int i = 0; i < 10; i++) begin
            clear_img();
            put(32'h100, enc_j(32'h20));
            put(32'h020, vt[i].ins);
            boot();
            wait_ret(1, 50);
            a1 = acc_cnt;
            if (vt[i].halt) begin
                k = 0;
                while (!halted && k < 30) begin
                    @(negedge clk);
                    k++;
                end
                chk($sformatf("vec%0d_halted", i), {31'h0, halted}, 32'h1);
                chk($sformatf("vec%0d_pc", i), pc, vt[i].npc);
                reqs = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (mem_req) reqs++;
                end
                chk($sformatf("vec%0d_req_after", i), 32'(reqs), 32'h0);
                chk($sformatf("vec%0d_accesses", i), 32'(acc_cnt - a1), 32'h1);
            end else begin
                wait_ret(2, 50);
                chk($sformatf("vec%0d_pc", i), pc, vt[i].npc);
                chk($sformatf("vec%0d_cyc", i), 32'(rc(2) - rc(1)), 32'(vt[i].cyc));
                chk($sformatf("vec%0d_halted", i), {31'h0, halted}, 32'h0);
            end
        end

        // Reset during a stalled store
        fixed_wait = 3;
        clear_img();
        put(32'h100, enc_i(6'h08, 0, 1, 16'd5));
        put(32'h104, enc_i(6'h2B, 0, 1, 16'h300));
        boot();
        k = 0;
        while (!(mem_req && mem_we) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mid_store_seen", {31'h0, mem_req && mem_we}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_req_drop", {31'h0, mem_req}, 32'h0);
        chk("mid_we_drop", {31'h0, mem_we}, 32'h0);
        a1 = acc_cnt;
        @(negedge clk);
        chk("mid_no_accept", 32'(acc_cnt - a1), 32'h0);
        chk("mid_no_write", mem[32'h300 >> 2], 32'h0);
        clear_img();
        put(32'h100, enc_i(6'h2B, 0, 1, 16'h304));
        put(32'h104, enc_i(6'h04, 0, 0, 16'hFFFF));
        put(32'h304, 32'h0000_DEAD);
        load_gen++;
        release_rst();
        #1;
        chk("mid_restart_addr", mem_addr, 32'h100);
        wait_ret(1, 50);
        chk("mid_regs_cleared", mem[32'h304 >> 2], 32'h0);

        // Random ALU programs with random wait states against an ISA model
        rand_mode = 1'b1;
        for (int it = 0; it < 3; it++) begin
            clear_img();
            for (int i = 0; i < 8; i++) r[i] = 32'h0;
            w = 32'h100;
            for (int i = 1; i < 8; i++) begin
                imm = $urandom;
                put(w, enc_i(6'h08, 0, i, imm[15:0]));
                r[i] = {{16{imm[15]}}, imm[15:0]};
                w += 4;
            end
            for (int n = 0; n < 12; n++) begin
                kind = $urandom_range(0, 8);
                rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
                imm = $urandom;
                case (kind)
                    0: begin put(w, enc_r(rs, rt, rd, 6'h20)); v = r[rs] + r[rt]; end
                    1: begin put(w, enc_r(rs, rt, rd, 6'h22)); v = r[rs] - r[rt]; end
                    2: begin put(w, enc_r(rs, rt, rd, 6'h24)); v = r[rs] & r[rt]; end
                    3: begin put(w, enc_r(rs, rt, rd, 6'h25)); v = r[rs] | r[rt]; end
                    4: begin put(w, enc_r(rs, rt, rd, 6'h2A)); v = ($signed(r[rs]) < $signed(r[rt])) ? 1 : 0; end
                    5: begin put(w, enc_i(6'h08, rs, rt, imm[15:0])); v = r[rs] + {{16{imm[15]}}, imm[15:0]}; end
                    6: begin put(w, enc_i(6'h0C, rs, rt, imm[15:0])); v = r[rs] & {16'h0, imm[15:0]}; end
                    7: begin put(w, enc_i(6'h0D, rs, rt, imm[15:0])); v = r[rs] | {16'h0, imm[15:0]}; end
                    default: begin
                        put(w, enc_i(6'h0A, rs, rt, imm[15:0]));
                        v = ($signed(r[rs]) < $signed({{16{imm[15]}}, imm[15:0]})) ? 1 : 0;
                    end
                endcase
                if (kind <= 4) begin
                    if (rd != 0) r[rd] = v;
                end else begin
                    if (rt != 0) r[rt] = v;
                end
                w += 4;
            end
            for (int i = 1; i < 8; i++) begin
                put(w, enc_i(6'h2B, 0, i, 16'(32'h400 + 4 * i)));
                w += 4;
            end
            put(w, enc_i(6'h04, 0, 0, 16'hFFFF));
            boot();
            wait_ret(26, 2000);
            exp_cyc = 26 * 4;
            for (int j = 0; j < 33; j++) exp_cyc += wlog[(a0 + j) % 1024];
            chk($sformatf("rnd%0d_cycles", it), 32'(rc(26)), 32'(exp_cyc));
            for (int i = 1; i < 8; i++)
                chk($sformatf("rnd%0d_r%0d", it, i), mem[(32'h400 + 4 * i) >> 2], r[i]);
        end
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
